// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin arbiter that runs atomic read-modify-write deposit/withdraw/query on an internal balance store for N_TERM terminals (in: clk, rst, req, op, acct, amt; out: gnt, done, rsp_balance, rsp_nack, busy)
module atm_account_arbiter #(
  parameter int N_TERM = 4,
  parameter int N_ACCT = 8,
  parameter int BAL_W = 8,
  parameter int AMT_W = 4,
  parameter int INIT_BAL = 20,
  localparam int ACCT_W = $clog2(N_ACCT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_TERM-1:0]        req,
  input  logic [2*N_TERM-1:0]      op,
  input  logic [ACCT_W*N_TERM-1:0] acct,
  input  logic [AMT_W*N_TERM-1:0]  amt,
  output logic [N_TERM-1:0]        gnt,
  output logic [N_TERM-1:0]        done,
  output logic [BAL_W-1:0]         rsp_balance,
  output logic                     rsp_nack,
  output logic                     busy
);
  localparam int TW = $clog2(N_TERM);
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [TW-1:0] w, ptr, pick;
  logic [1:0] op_sel, op_r;
  logic [ACCT_W-1:0] a_sel, a_r;
  logic [AMT_W-1:0] amt_sel, amt_r;
  logic [BAL_W-1:0] b, res;
  logic [BAL_W-1:0] bal [N_ACCT];
  logic [BAL_W:0] sum;
  logic oor, nack, wr;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? GRANT : IDLE;
      GRANT:   nxt = EXEC;
      EXEC:    nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    gnt = state == IDLE ? '0 : N_TERM'(1) << w;
    done = state == RESP ? N_TERM'(1) << w : '0;
    busy = state != IDLE;
  end
  always_comb begin
    pick = ptr;
    for (int i = N_TERM; i >= 1; i--)
      if (req[(int'(ptr) + i) % N_TERM]) pick = TW'((int'(ptr) + i) % N_TERM);
  end
  always_comb begin
    op_sel = op[2*w +: 2];
    a_sel = acct[ACCT_W*w +: ACCT_W];
    amt_sel = amt[AMT_W*w +: AMT_W];
  end
  always_comb begin
    sum = {1'b0, b} + (BAL_W+1)'(amt_r);
    oor = int'(a_r) >= N_ACCT;
    nack = oor | (op_r == 2'b00) | (op_r == 2'b01 & sum[BAL_W]) |
           (op_r == 2'b10 & (BAL_W+1)'(amt_r) > {1'b0, b});
    res = nack ? b : op_r == 2'b01 ? sum[BAL_W-1:0] : op_r == 2'b10 ? b - BAL_W'(amt_r) : b;
    wr = ~nack & (op_r != 2'b11);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= TW'(N_TERM - 1);
      w <= '0;
      op_r <= '0;
      a_r <= '0;
      amt_r <= '0;
      b <= '0;
      rsp_balance <= '0;
      rsp_nack <= 1'b0;
      for (int i = 0; i < N_ACCT; i++) bal[i] <= BAL_W'(INIT_BAL);
    end else begin
      if (state == IDLE) w <= pick;
      if (state == GRANT) begin
        ptr <= w;
        op_r <= op_sel;
        a_r <= a_sel;
        amt_r <= amt_sel;
        b <= int'(a_sel) < N_ACCT ? bal[a_sel] : '0;
      end
      if (state == EXEC) begin
        rsp_balance <= res;
        rsp_nack <= nack;
        if (wr) bal[a_r] <= res;
      end
    end
  end
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb_atm_account_arbiter: scoreboard bench driving directed transactions and checking done/rsp against queued expectations
module tb_atm_account_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] op = '0;
  logic [11:0] acct = '0;
  logic [15:0] amt = '0;
  logic [3:0] gnt, done;
  logic [7:0] rsp_balance;
  logic rsp_nack, busy;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int t; int b; int n; int c;} exp_t;
  exp_t q[$];
  exp_t me;
  atm_account_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .acct(acct), .amt(amt),
    .gnt(gnt), .done(done), .rsp_balance(rsp_balance), .rsp_nack(rsp_nack), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    if (done != 4'b0) begin
      if (q.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        me = q.pop_front();
        chk("done_term", int'(done), 1 << me.t);
        chk("done_cycle", cyc, me.c);
        chk("rsp_balance", int'(rsp_balance), me.b);
        chk("rsp_nack", int'(rsp_nack), me.n);
        chk("gnt_in_resp", int'(gnt), int'(done));
      end
    end
  end
  task automatic set_in(input int t, input logic [1:0] o, input int a, input int m);
    op[2*t +: 2] = o;
    acct[3*t +: 3] = 3'(a);
    amt[4*t +: 4] = 4'(m);
  endtask
  task automatic wait_done(input int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[t] && n < 60);
    chk("done_timeout", int'(done[t]), 1);
    req[t] = 1'b0;
  endtask
  task automatic txn(input int t, input logic [1:0] o, input int a, input int m, input int eb, input int en);
    @(negedge clk);
    set_in(t, o, a, m);
    q.push_back('{t, eb, en, cyc + 3});
    req[t] = 1'b1;
    wait_done(t);
  endtask
  initial begin
    int c0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_balance", int'(rsp_balance), 0);
    chk("rst_nack", int'(rsp_nack), 0);
    txn(0, 2'b11, 3, 0, 20, 0);
    txn(1, 2'b01, 2, 15, 35, 0);
    txn(1, 2'b11, 2, 0, 35, 0);
    txn(2, 2'b10, 1, 15, 5, 0);
    txn(2, 2'b10, 1, 15, 5, 1);
    txn(2, 2'b11, 1, 0, 5, 0);
    for (int i = 1; i <= 15; i++) txn(3, 2'b01, 4, 15, 20 + 15 * i, 0);
    txn(3, 2'b01, 4, 15, 245, 1);
    txn(3, 2'b01, 4, 10, 255, 0);
    txn(3, 2'b01, 4, 1, 255, 1);
    @(negedge clk);
    c0 = cyc;
    set_in(0, 2'b11, 4, 0);
    set_in(1, 2'b11, 2, 0);
    set_in(2, 2'b01, 1, 3);
    set_in(3, 2'b10, 3, 5);
    q.push_back('{0, 255, 0, c0 + 3});
    q.push_back('{1, 35, 0, c0 + 7});
    q.push_back('{2, 8, 0, c0 + 11});
    q.push_back('{3, 15, 0, c0 + 15});
    req = 4'b1111;
    wait_done(0);
    @(negedge clk);
    set_in(0, 2'b11, 1, 0);
    q.push_back('{0, 8, 0, c0 + 19});
    req[0] = 1'b1;
    wait_done(1);
    wait_done(2);
    wait_done(3);
    wait_done(0);
    txn(3, 2'b00, 2, 5, 35, 1);
    txn(1, 2'b10, 3, 15, 0, 0);
    txn(1, 2'b11, 3, 0, 0, 0);
    txn(1, 2'b10, 3, 1, 0, 1);
    txn(2, 2'b11, 1, 0, 8, 0);
    @(negedge clk);
    set_in(0, 2'b10, 0, 10);
    req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("exec_busy", int'(busy), 1);
    chk("exec_gnt", int'(gnt), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_balance", int'(rsp_balance), 0);
    chk("abort_nack", int'(rsp_nack), 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    txn(0, 2'b11, 0, 0, 20, 0);
    txn(2, 2'b11, 4, 0, 20, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
